rf_wb_arbiter: RTL

Write-port arbiter for the 8×16-bit register file. Two writeback sources share the register file's single write port: requester 0 is ALU writeback and requester 1 is load/multi-cycle writeback. Each source has a one-entry holding buffer with a valid/ready handshake, and the block grants round-robin with an age override for same-register conflicts. Its registered outputs drive the register file write port directly. It also exports a pending-write mask for decode hazard detection.

---
 rtl/rf_wb_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// Write-port arbiter for the 8x16 register file: two one-entry writeback buffers,
// round-robin grant with age ordering for same-register conflicts, registered write port.
module rf_wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [2:0]  req0_reg,
  input  logic [15:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [2:0]  req1_reg,
  input  logic [15:0] req1_data,
  output logic        req1_ready,
  output logic        writeEn,
  output logic [2:0]  writeRegSel,
  output logic [15:0] writeData,
  output logic [7:0]  pending,
  output logic        err
);

  logic [1:0]  w_valid;
  logic [2:0]  w_in_reg  [2];
  logic [15:0] w_in_data [2];

  logic [1:0]  r_full;
  logic [2:0]  r_reg  [2];
  logic [15:0] r_data [2];
  logic        r_rr;
  logic        r_old;

  logic        r_write_en;
  logic [2:0]  r_write_sel;
  logic [15:0] r_write_data;

  logic        w_grant_any;
  logic        w_grant_idx;
  logic [1:0]  w_grant;
  logic [1:0]  w_ready;
  logic [1:0]  w_load;
  logic        w_old_next;

  assign w_valid      = {req1_valid, req0_valid};
  assign w_in_reg[0]  = req0_reg;
  assign w_in_reg[1]  = req1_reg;
  assign w_in_data[0] = req0_data;
  assign w_in_data[1] = req1_data;

  // Grant depends on buffer state only, so ready never combinationally follows valid.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = 1'b0;
    case (r_full)
      2'b01: begin
        w_grant_any = 1'b1;
        w_grant_idx = 1'b0;
      end
      2'b10: begin
        w_grant_any = 1'b1;
        w_grant_idx = 1'b1;
      end
      2'b11: begin
        w_grant_any = 1'b1;
        w_grant_idx = (r_reg[0] == r_reg[1]) ? r_old : r_rr;
      end
      default: begin
        w_grant_any = 1'b0;
        w_grant_idx = 1'b0;
      end
    endcase
  end

  assign w_grant    = w_grant_any ? (w_grant_idx ? 2'b10 : 2'b01) : 2'b00;
  assign w_ready    = ~r_full | w_grant;
  assign w_load     = w_valid & w_ready;
  assign req0_ready = w_ready[0];
  assign req1_ready = w_ready[1];

  // A buffer refilled on its own grant edge is younger than one that stayed full.
  always_comb begin
    w_old_next = r_old;
    if (w_load == 2'b11)
      w_old_next = 1'b0;
    else if (w_load[0] && r_full[1] && !w_grant[1])
      w_old_next = 1'b1;
    else if (w_load[1] && r_full[0] && !w_grant[0])
      w_old_next = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        r_full[i] <= 1'b0;
        r_reg[i]  <= 3'd0;
        r_data[i] <= 16'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_load[i]) begin
          r_full[i] <= 1'b1;
          r_reg[i]  <= w_in_reg[i];
          r_data[i] <= w_in_data[i];
        end else if (w_grant[i]) begin
          r_full[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr  <= 1'b0;
      r_old <= 1'b0;
    end else begin
      r_old <= w_old_next;
      if (w_grant_any)
        r_rr <= ~w_grant_idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_write_en   <= 1'b0;
      r_write_sel  <= 3'd0;
      r_write_data <= 16'd0;
    end else begin
      r_write_en <= w_grant_any;
      if (w_grant_any) begin
        r_write_sel  <= r_reg[w_grant_idx];
        r_write_data <= r_data[w_grant_idx];
      end
    end
  end

  assign writeEn     = r_write_en;
  assign writeRegSel = r_write_sel;
  assign writeData   = r_write_data;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_pending
      assign pending[gi] = (r_full[0] && (r_reg[0] == 3'(gi))) ||
                           (r_full[1] && (r_reg[1] == 3'(gi))) ||
                           (r_write_en && (r_write_sel == 3'(gi)));
    end
  endgenerate

  always_comb begin
    err = (req0_valid && ($isunknown(req0_reg) || $isunknown(req0_data))) ||
          (req1_valid && ($isunknown(req1_reg) || $isunknown(req1_data)));
  end

endmodule
